// File: rtl/instr_pkg.sv
// Shared widths and word type for the two-half instruction register.
package instr_pkg;

  localparam int INSTR_HALF_W = 8;
  localparam int INSTR_W      = 2 * INSTR_HALF_W;

  typedef logic [INSTR_W-1:0] instr_word_t;

endpackage : instr_pkg

// File: rtl/half_reg.sv
// One half of the instruction word: enabled data register plus a sticky
// "loaded" flag that a synchronous clear drops unless the same cycle loads.
module half_reg #(
  parameter int BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [BITS-1:0] d_i,
  input  logic            load_i,
  input  logic            clr_i,
  output logic [BITS-1:0] q_o,
  output logic            loaded_o
);

  logic [BITS-1:0] data_q, data_d;
  logic            loaded_q, loaded_d;

  always_comb begin
    data_d   = data_q;
    loaded_d = loaded_q;
    if (load_i) begin
      data_d   = d_i;
      loaded_d = 1'b1;
    end else if (clr_i) begin
      // clr only touches the flag; a load in the same cycle takes priority
      loaded_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q   <= '0;
      loaded_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      loaded_q <= loaded_d;
    end
  end

  assign q_o      = data_q;
  assign loaded_o = loaded_q;

endmodule : half_reg

// File: rtl/instruction_reg.sv
// Assembles a 2*BITS instruction word from a narrow bus written one half at a
// time; full tells the decoder both halves have been written since reset/clr.
module instruction_reg
  import instr_pkg::*;
#(
  parameter int BITS = INSTR_HALF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS-1:0]   in,
  input  logic              set_hi,
  input  logic              set_lo,
  input  logic              clr,
  output logic [2*BITS-1:0] out,
  output logic              hi_loaded,
  output logic              lo_loaded,
  output logic              full
);

  logic [BITS-1:0] hi_q, lo_q;

  half_reg #(.BITS(BITS)) u_hi (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .d_i      (in),
    .load_i   (set_hi),
    .clr_i    (clr),
    .q_o      (hi_q),
    .loaded_o (hi_loaded)
  );

  half_reg #(.BITS(BITS)) u_lo (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .d_i      (in),
    .load_i   (set_lo),
    .clr_i    (clr),
    .q_o      (lo_q),
    .loaded_o (lo_loaded)
  );

  assign out  = {hi_q, lo_q};
  assign full = hi_loaded & lo_loaded;

endmodule : instruction_reg

// File: tb/tb_instruction_reg.sv
// Scoreboard bench for instruction_reg: a behavioural model pushes the expected
// word/flags each driven cycle, and each test pops and compares after the edge.
module tb_instruction_reg;
  import instr_pkg::*;

  localparam int BITS = INSTR_HALF_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BITS-1:0]   in;
  logic              set_hi, set_lo, clr;
  instr_word_t       out;
  logic              hi_loaded, lo_loaded, full;

  instruction_reg #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .set_hi    (set_hi),
    .set_lo    (set_lo),
    .clr       (clr),
    .out       (out),
    .hi_loaded (hi_loaded),
    .lo_loaded (lo_loaded),
    .full      (full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    instr_word_t o;
    logic        h;
    logic        l;
    logic        f;
  } obs_t;

  obs_t sb[$];
  int checks   = 0;
  int failures = 0;

  logic [BITS-1:0] m_hi, m_lo;
  logic            m_fh, m_fl;

  function automatic obs_t observe();
    return {out, hi_loaded, lo_loaded, full};
  endfunction

  function automatic obs_t pop_exp();
    obs_t e;
    if (sb.size() == 0) return '1;
    e = sb.pop_front();
    return e;
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_fh = 1'b0; m_fl = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle, update the model, queue the expectation, then sit #1 past the edge.
  task automatic drive_cycle(input logic [BITS-1:0] d, input logic sh, input logic sl,
                             input logic c);
    @(negedge clk);
    in = d; set_hi = sh; set_lo = sl; clr = c;
    if (sh) begin m_hi = d; m_fh = 1'b1; end else if (c) m_fh = 1'b0;
    if (sl) begin m_lo = d; m_fl = 1'b1; end else if (c) m_fl = 1'b0;
    sb.push_back({m_hi, m_lo, m_fh, m_fl, m_fh & m_fl});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t zero;
    zero = '0;
    rst_n = 1'b0; in = 8'hFF; set_hi = 1'b1; set_lo = 1'b1; clr = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observe() !== zero) begin
      failures++;
      $display("FAIL reset_t0 got=%h want=%h", observe(), zero);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (observe() !== zero) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, observe(), zero);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; set_hi = 1'b0; set_lo = 1'b0;
    drive_cycle(8'hFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (observe() !== pop_exp()) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", observe(), zero);
    end
  endtask

  task automatic test_hi_load();
    obs_t e;
    drive_cycle(8'h33, 1'b1, 1'b0, 1'b0);
    e = pop_exp();
    checks++;
    if (observe() !== e || out !== 16'h3300) begin
      failures++;
      $display("FAIL hi_load got=%h want=%h", observe(), e);
    end
  endtask

  task automatic test_lo_load();
    obs_t e;
    drive_cycle(8'h0F, 1'b0, 1'b1, 1'b0);
    e = pop_exp();
    checks++;
    if (observe() !== e || out !== 16'h330F || full !== 1'b1) begin
      failures++;
      $display("FAIL lo_load got=%h want=%h", observe(), e);
    end
  endtask

  task automatic test_hold();
    obs_t e;
    for (int i = 0; i < 6; i++) begin
      drive_cycle((i == 5) ? 8'hxx : ((i % 2) ? 8'h55 : 8'hAA), 1'b0, 1'b0, 1'b0);
      e = pop_exp();
      checks++;
      if (observe() !== e) begin
        failures++;
        $display("FAIL hold cyc=%0d got=%h want=%h", i, observe(), e);
      end
    end
  endtask

  task automatic test_simultaneous();
    obs_t e;
    drive_cycle(8'hC3, 1'b1, 1'b1, 1'b0);
    e = pop_exp();
    checks++;
    if (observe() !== e || out !== 16'hC3C3) begin
      failures++;
      $display("FAIL simul_load got=%h want=%h", observe(), e);
    end
    drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);
    e = pop_exp();
    checks++;
    if (observe() !== e) begin
      failures++;
      $display("FAIL clr_only got=%h want=%h", observe(), e);
    end
  endtask

  task automatic test_clr_vs_load();
    obs_t e;
    drive_cycle(8'h5A, 1'b0, 1'b1, 1'b1);
    e = pop_exp();
    checks++;
    if (observe() !== e || out !== 16'hC35A) begin
      failures++;
      $display("FAIL clr_vs_lo got=%h want=%h", observe(), e);
    end
    drive_cycle(8'hE1, 1'b1, 1'b0, 1'b1);
    e = pop_exp();
    checks++;
    if (observe() !== e) begin
      failures++;
      $display("FAIL clr_vs_hi got=%h want=%h", observe(), e);
    end
    drive_cycle(8'h00, 1'b0, 1'b0, 1'b0);
    void'(pop_exp());
  endtask

  task automatic test_async_reset();
    obs_t e, zero;
    zero = '0;
    drive_cycle(8'h77, 1'b1, 1'b0, 1'b0);
    e = pop_exp();
    checks++;
    if (observe() !== e) begin
      failures++;
      $display("FAIL pre_async got=%h want=%h", observe(), e);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observe() !== zero) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", observe(), zero);
    end
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (observe() !== zero) begin
      failures++;
      $display("FAIL async_hold got=%h want=%h", observe(), zero);
    end
    @(negedge clk);
    rst_n = 1'b1; set_hi = 1'b0; set_lo = 1'b0;
    drive_cycle(8'h12, 1'b0, 1'b1, 1'b0);
    e = pop_exp();
    checks++;
    if (observe() !== e || out !== 16'h0012) begin
      failures++;
      $display("FAIL restart got=%h want=%h", observe(), e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(BITS'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      e = pop_exp();
      checks++;
      if (observe() !== e) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%h want=%h", i, observe(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hi_load();
    test_lo_load();
    test_hold();
    test_simultaneous();
    test_clr_vs_load();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instruction_reg

// File: doc/instruction_reg.md
Name: instruction_reg

Overview:
- Two-half instruction register. Assembles a 2*BITS-wide instruction word from a BITS-wide input bus, which is written in two separate cycles: one for the high half and one for the low half.
- Sits between the host/command interface (narrow bus) and the accelerator instruction decoder (wide word).
- Per-half load tracking tells downstream logic when a complete word is held.

Parameters:
- BITS, 8, width of the input bus and of each half; output width is 2*BITS. Legal range BITS >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  BITS  data written into the selected half.
- set_hi  input  1  load in into out[2*BITS-1:BITS] on the next rising clk.
- set_lo  input  1  load in into out[BITS-1:0] on the next rising clk.
- clr  input  1  synchronous clear of the load flags only; data is unchanged.
- out  output  2*BITS  registered instruction word.
- hi_loaded  output  1  high half written since the last reset/clr.
- lo_loaded  output  1  low half written since the last reset/clr.
- full  output  1  hi_loaded AND lo_loaded.

Behaviour:
- Reset:
  - rst_n low clears out, hi_loaded and lo_loaded to 0 immediately, with no clock required.
  - Registers hold 0 while rst_n is low.
  - The first capture after release happens on the first rising clk with rst_n high.
- Load timing:
  - Loads are edge-triggered with 1-cycle latency.
  - A value sampled on in at the rising edge where set_x=1 appears on out immediately after that edge.
- Independent halves:
  - set_hi writes only the high half.
  - set_lo writes only the low half.
  - The half not selected keeps its previous value.
- set_hi=1 and set_lo=1 in the same cycle: both halves take in, so out={in,in}, and both flags set.
- Both strobes low: out holds.
- Repeated writes to the same half overwrite it; no error.
- Flags:
  - hi_loaded is set on any set_hi cycle; lo_loaded is set on any set_lo cycle.
  - Flags are sticky until clr or reset.
- clr precedence:
  - If clr=1 and a set strobe are both active in the same cycle, the data load still happens and the corresponding flag ends at 1 (set wins over clr).
  - The flag of a half that is not being loaded goes to 0.
- full is combinational from the two flag registers; it has no extra latency.
- X on in while the strobes are low must not propagate to out.
- Asserting reset mid-sequence (for example after only the high half is loaded) zeroes everything, and the sequence restarts.

Decomposition:
- Shared package instr_pkg:
  - default BITS constant INSTR_HALF_W = 8;
  - derived INSTR_W = 2*INSTR_HALF_W;
  - typedef instr_word_t sized INSTR_W.
- One natural sub-module, half_reg: a BITS-wide enabled register with async active-low reset plus a sticky loaded flag with clr. Instantiate it twice (hi, lo). Top level concatenates the two data outputs and ANDs the two flags.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in=0xFF and both strobes=1 -> out=0x0000, hi_loaded=lo_loaded=full=0 throughout.
- High-half load: in=0x33, set_hi=1 for one cycle -> next cycle out=0x3300, hi_loaded=1, lo_loaded=0, full=0.
- Low-half load: then in=0x0F, set_lo=1 for one cycle -> out=0x330F, full=1.
- Hold: with the strobes low, in toggles 0xAA/0x55 for 5 cycles -> out stays 0x330F.
- Simultaneous load: set_hi=set_lo=1 with in=0xC3 -> out=0xC3C3, both flags=1. Then clr=1 alone -> flags=0, out stays 0xC3C3.
- Clear vs load and async reset:
  - clr=1 with set_lo=1, in=0x5A -> out low=0x5A, lo_loaded=1, hi_loaded=0.
  - Dropping rst_n mid-cycle zeroes out before the next edge.
